// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM arbiter: FSM state encoding, counter width and
// the address-window test used for both requesters.
package bram_arb_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCpuAcc,
    StCpuResp,
    StAuxAcc,
    StAuxResp
  } state_e;

  function automatic logic in_window(logic [15:0] addr, logic [15:0] base, int unsigned size);
    logic [31:0] off;
    off = {16'h0000, addr} - {16'h0000, base};
    return (addr >= base) && (off < size);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load; holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bram_arb.sv
// Two-requester arbiter for a single-port BRAM window: a phi2-timed CPU with priority and
// a req/ack aux port. Access counters are built only with BRAM_ARB_STATS_EN defined.
module bram_arb
  import bram_arb_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned SIZE      = 8192
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_phi2,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data,
  input  logic        i_cpu_rw,
  output logic [7:0]  o_cpu_data,
  input  logic        i_aux_req,
  input  logic [15:0] i_aux_addr,
  input  logic [7:0]  i_aux_wdata,
  input  logic        i_aux_rw,
  output logic        o_aux_ack,
  output logic [7:0]  o_aux_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output logic [15:0] o_stat_cpu,
  output logic [15:0] o_stat_aux
);

  state_e      state_q, state_d;
  logic        phi2_q, pend_q, pend_d;
  logic        rise, rise_hit, cpu_go, start_cpu, aux_hit;
  logic [15:0] cpu_addr_q, cpu_addr_s;
  logic [7:0]  cpu_wdata_q, cpu_wdata_s;
  logic        cpu_rw_q, cpu_rw_s;
  logic        aux_hit_q, aux_hit_d, aux_rw_q, aux_rw_d;
  logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d, cpu_data_q, cpu_data_d;

  assign rise     = i_cpu_phi2 & ~phi2_q;
  assign rise_hit = rise & in_window(i_cpu_addr, BASE_ADDR, SIZE);
  assign cpu_go   = rise_hit | pend_q;
  assign aux_hit  = in_window(i_aux_addr, BASE_ADDR, SIZE);

  // A rise this cycle uses the live bus; a deferred access uses the fields captured at its rise.
  assign cpu_addr_s  = rise_hit ? i_cpu_addr : cpu_addr_q;
  assign cpu_wdata_s = rise_hit ? i_cpu_data : cpu_wdata_q;
  assign cpu_rw_s    = rise_hit ? i_cpu_rw   : cpu_rw_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_data_d  = cpu_data_q;
    aux_hit_d   = aux_hit_q;
    aux_rw_d    = aux_rw_q;
    start_cpu   = 1'b0;

    if (rise_hit && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_go) begin
          start_cpu = 1'b1;
        end else if (!i_cpu_phi2 && i_aux_req) begin
          state_d     = StAuxAcc;
          aux_hit_d   = aux_hit;
          aux_rw_d    = i_aux_rw;
          mem_en_d    = aux_hit;
          mem_we_d    = aux_hit & ~i_aux_rw;
          mem_addr_d  = i_aux_addr - BASE_ADDR;
          mem_wdata_d = i_aux_wdata;
        end
      end
      StCpuAcc: state_d = StCpuResp;
      StCpuResp: begin
        if (cpu_rw_q) begin
          cpu_data_d = i_mem_rdata;
        end
        if (cpu_go) begin
          start_cpu = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StAuxAcc: state_d = StAuxResp;
      StAuxResp: begin
        if (cpu_go) begin
          start_cpu = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_cpu) begin
      state_d     = StCpuAcc;
      pend_d      = 1'b0;
      mem_en_d    = 1'b1;
      mem_we_d    = ~cpu_rw_s;
      mem_addr_d  = cpu_addr_s - BASE_ADDR;
      mem_wdata_d = cpu_wdata_s;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      phi2_q      <= 1'b0;
      pend_q      <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_rw_q    <= 1'b0;
      aux_hit_q   <= 1'b0;
      aux_rw_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      phi2_q      <= i_cpu_phi2;
      pend_q      <= pend_d;
      aux_hit_q   <= aux_hit_d;
      aux_rw_q    <= aux_rw_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_data_q  <= cpu_data_d;
      if (rise_hit) begin
        cpu_addr_q  <= i_cpu_addr;
        cpu_wdata_q <= i_cpu_data;
        cpu_rw_q    <= i_cpu_rw;
      end
    end
  end

  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_cpu_data  = cpu_data_q;

  // Memory read data is only valid in AUX_RESP, so the aux response is decoded from state.
  assign o_aux_ack   = (state_q == StAuxResp);
  assign o_aux_rdata = (o_aux_ack && aux_hit_q && aux_rw_q) ? i_mem_rdata : 8'h00;

`ifdef BRAM_ARB_STATS_EN
  sat_counter #(
    .Width(STAT_W)
  ) u_cnt_cpu (
    .clk_i   (i_clk),
    .clr_i   (!i_reset_n),
    .inc_i   (state_q == StCpuResp),
    .ld_i    (1'b0),
    .ld_val_i({STAT_W{1'b0}}),
    .cnt_o   (o_stat_cpu)
  );

  sat_counter #(
    .Width(STAT_W)
  ) u_cnt_aux (
    .clk_i   (i_clk),
    .clr_i   (!i_reset_n),
    .inc_i   (o_aux_ack & aux_hit_q),
    .ld_i    (1'b0),
    .ld_val_i({STAT_W{1'b0}}),
    .cnt_o   (o_stat_aux)
  );
`else
  assign o_stat_cpu = '0;
  assign o_stat_aux = '0;
`endif

endmodule

// File: tb/tb_bram_arb.sv
// Directed bench for bram_arb: two instances (window at 0x0000 and at 0x1000) share stimulus,
// each backed by a registered-read memory model; plus a standalone sat_counter check.
module tb_bram_arb;

  logic        clk = 1'b0;
  logic        i_reset_n, i_cpu_phi2, i_cpu_rw, i_aux_req, i_aux_rw;
  logic [15:0] i_cpu_addr, i_aux_addr;
  logic [7:0]  i_cpu_data, i_aux_wdata;

  logic [7:0]  o_cpu_data0, o_aux_rdata0, o_mem_wdata0, rdata0;
  logic        o_aux_ack0, o_mem_en0, o_mem_we0;
  logic [15:0] o_mem_addr0, o_stat_cpu0, o_stat_aux0;
  logic [7:0]  o_cpu_data1, o_aux_rdata1, o_mem_wdata1, rdata1;
  logic        o_aux_ack1, o_mem_en1, o_mem_we1;
  logic [15:0] o_mem_addr1, o_stat_cpu1, o_stat_aux1;

  logic        sc_clr, sc_inc, sc_ld;
  logic [15:0] sc_val, sc_cnt;

  logic [7:0]  mem0 [8192];
  logic [7:0]  mem1 [8192];
  int          en_cnt0 = 0, en_cnt1 = 0, ack_cnt0 = 0, we_viol = 0;
  int          n_vec = 0, n_err = 0;
  int          e0, e1, a0;
  logic        ok, early, ack1_seen;
  logic [7:0]  rd, rd1;

  always #5 clk = ~clk;

  bram_arb #(.BASE_ADDR(16'h0000), .SIZE(8192)) u_dut0 (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_cpu_phi2(i_cpu_phi2), .i_cpu_addr(i_cpu_addr),
    .i_cpu_data(i_cpu_data), .i_cpu_rw(i_cpu_rw), .o_cpu_data(o_cpu_data0),
    .i_aux_req(i_aux_req), .i_aux_addr(i_aux_addr), .i_aux_wdata(i_aux_wdata),
    .i_aux_rw(i_aux_rw), .o_aux_ack(o_aux_ack0), .o_aux_rdata(o_aux_rdata0),
    .o_mem_en(o_mem_en0), .o_mem_we(o_mem_we0), .o_mem_addr(o_mem_addr0),
    .o_mem_wdata(o_mem_wdata0), .i_mem_rdata(rdata0),
    .o_stat_cpu(o_stat_cpu0), .o_stat_aux(o_stat_aux0)
  );

  bram_arb #(.BASE_ADDR(16'h1000), .SIZE(8192)) u_dut1 (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_cpu_phi2(i_cpu_phi2), .i_cpu_addr(i_cpu_addr),
    .i_cpu_data(i_cpu_data), .i_cpu_rw(i_cpu_rw), .o_cpu_data(o_cpu_data1),
    .i_aux_req(i_aux_req), .i_aux_addr(i_aux_addr), .i_aux_wdata(i_aux_wdata),
    .i_aux_rw(i_aux_rw), .o_aux_ack(o_aux_ack1), .o_aux_rdata(o_aux_rdata1),
    .o_mem_en(o_mem_en1), .o_mem_we(o_mem_we1), .o_mem_addr(o_mem_addr1),
    .o_mem_wdata(o_mem_wdata1), .i_mem_rdata(rdata1),
    .o_stat_cpu(o_stat_cpu1), .o_stat_aux(o_stat_aux1)
  );

  sat_counter #(.Width(16)) u_sc (
    .clk_i(clk), .clr_i(sc_clr), .inc_i(sc_inc), .ld_i(sc_ld), .ld_val_i(sc_val),
    .cnt_o(sc_cnt)
  );

  // Memory models: preset pattern during reset, registered read, write-through on we.
  always @(posedge clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 8192; i++) begin
        mem0[i] <= 8'(i * 7 + 3);
        mem1[i] <= 8'(i * 7 + 3);
      end
      mem0[16] <= 8'hA5;
      mem0[4]  <= 8'h5A;
    end
    if (o_mem_en0) begin
      en_cnt0 <= en_cnt0 + 1;
      rdata0  <= mem0[o_mem_addr0[12:0]];
      if (o_mem_we0) mem0[o_mem_addr0[12:0]] <= o_mem_wdata0;
    end
    if (o_mem_en1) begin
      en_cnt1 <= en_cnt1 + 1;
      rdata1  <= mem1[o_mem_addr1[12:0]];
      if (o_mem_we1) mem1[o_mem_addr1[12:0]] <= o_mem_wdata1;
    end
    if (o_aux_ack0) ack_cnt0 <= ack_cnt0 + 1;
    if ((!o_mem_en0 && o_mem_we0) || (!o_mem_en1 && o_mem_we1)) we_viol <= we_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_rise(input logic [15:0] a, input logic [7:0] d, input logic rw);
    i_cpu_addr = a;
    i_cpu_data = d;
    i_cpu_rw   = rw;
    i_cpu_phi2 = 1'b1;
  endtask

  task automatic cpu_access(input logic [15:0] a, input logic [7:0] d, input logic rw);
    cpu_rise(a, d, rw);
    repeat (5) @(negedge clk);
    i_cpu_phi2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic aux_start(input logic [15:0] a, input logic [7:0] d, input logic rw);
    i_aux_req   = 1'b1;
    i_aux_addr  = a;
    i_aux_wdata = d;
    i_aux_rw    = rw;
  endtask

  // Bounded wait for the u_dut0 ack; u_dut1's response in that same cycle is recorded too.
  task automatic aux_xfer(input logic [15:0] a, input logic [7:0] d, input logic rw,
                          output logic got, output logic [7:0] data);
    aux_start(a, d, rw);
    got  = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (o_aux_ack0) begin
        got       = 1'b1;
        data      = o_aux_rdata0;
        ack1_seen = o_aux_ack1;
        rd1       = o_aux_rdata1;
      end
    end
    i_aux_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset_n = 1'b0; i_cpu_phi2 = 1'b0; i_cpu_addr = '0; i_cpu_data = '0; i_cpu_rw = 1'b1;
    i_aux_req = 1'b0; i_aux_addr = '0; i_aux_wdata = '0; i_aux_rw = 1'b1;
    sc_clr = 1'b1; sc_inc = 1'b0; sc_ld = 1'b0; sc_val = '0;
    ack1_seen = 1'b0; rd1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_data", o_cpu_data0, 0);
    check("rst_ack_rdata", {o_aux_ack0, o_aux_rdata0}, 0);
    check("rst_mem", {o_mem_en0, o_mem_we0, o_mem_addr0, o_mem_wdata0}, 0);
    check("rst_stats", {o_stat_cpu0, o_stat_aux0}, 0);
    check("sc_clr", sc_cnt, 16'h0000);
    i_reset_n = 1'b1;
    sc_clr = 1'b0;
    repeat (2) @(negedge clk);

    // CPU read of 0x0010: one enable, addr 0x0010, we 0; data at rise+2.
    e0 = en_cnt0; e1 = en_cnt1;
    cpu_rise(16'h0010, 8'h00, 1'b1);
    @(negedge clk);
    check("rd_en", o_mem_en0, 1);
    check("rd_addr", o_mem_addr0, 16'h0010);
    check("rd_we", o_mem_we0, 0);
    repeat (2) @(negedge clk);
    check("rd_data", o_cpu_data0, 8'hA5);
    repeat (3) @(negedge clk);
    i_cpu_phi2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_en_count", en_cnt0 - e0, 1);
    check("oow_lo_en_count", en_cnt1 - e1, 0);
    check("oow_lo_cpu_data", o_cpu_data1, 8'h00);

    // CPU write of 0x1FFF, then read back on both windows.
    e0 = en_cnt0;
    cpu_rise(16'h1FFF, 8'h3C, 1'b0);
    @(negedge clk);
    check("wr_en_we", {o_mem_en0, o_mem_we0}, 2'b11);
    check("wr_wdata", o_mem_wdata0, 8'h3C);
    check("wr_addr_hi", o_mem_addr1, 16'h0FFF);
    repeat (4) @(negedge clk);
    i_cpu_phi2 = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_en_count", en_cnt0 - e0, 1);
    cpu_access(16'h1FFF, 8'h00, 1'b1);
    check("wr_readback", o_cpu_data0, 8'h3C);
    check("wr_readback_hi", o_cpu_data1, 8'h3C);

    // Collision: aux read enters AUX_ACC, phi2 rises the next cycle.
    e1 = en_cnt1;
    aux_start(16'h0004, 8'h00, 1'b1);
    @(negedge clk);
    check("col_aux_en", {o_mem_en0, o_mem_we0, o_mem_addr0}, {2'b10, 16'h0004});
    cpu_rise(16'h0010, 8'h00, 1'b1);
    @(negedge clk);
    check("col_ack", {o_aux_ack0, o_aux_rdata0}, {1'b1, 8'h5A});
    check("col_ack_oow", {o_aux_ack1, o_aux_rdata1}, {1'b1, 8'h00});
    i_aux_req = 1'b0;
    @(negedge clk);
    check("col_cpu_acc", {o_aux_ack0, o_mem_en0, o_mem_addr0}, {2'b01, 16'h0010});
    repeat (2) @(negedge clk);
    check("col_cpu_data", o_cpu_data0, 8'hA5);
    repeat (2) @(negedge clk);
    i_cpu_phi2 = 1'b0;
    repeat (3) @(negedge clk);
    check("col_oow_en_count", en_cnt1 - e1, 0);

    // Outside both windows: no enable, read data held.
    e0 = en_cnt0; e1 = en_cnt1;
    cpu_access(16'h3000, 8'h00, 1'b1);
    check("oow_cpu_en_count", (en_cnt0 - e0) + (en_cnt1 - e1), 0);
    check("oow_cpu_data", {o_cpu_data0, o_cpu_data1}, {8'hA5, 8'h3C});

    // Aux write then aux read at the window edge below 0x1000.
    e1 = en_cnt1;
    aux_start(16'h0100, 8'h77, 1'b0);
    @(negedge clk);
    check("aux_wr_mem", {o_mem_en0, o_mem_we0, o_mem_addr0, o_mem_wdata0},
          {2'b11, 16'h0100, 8'h77});
    @(negedge clk);
    check("aux_wr_ack", {o_aux_ack0, o_aux_rdata0}, {1'b1, 8'h00});
    i_aux_req = 1'b0;
    @(negedge clk);
    check("aux_ack_pulse", o_aux_ack0, 0);
    aux_xfer(16'h0FFF, 8'h00, 1'b1, ok, rd);
    check("aux_0fff", {ok, rd}, {1'b1, 8'hFC});
    check("aux_0fff_oow", {ack1_seen, rd1}, {1'b1, 8'h00});
    check("aux_oow_en_count", en_cnt1 - e1, 0);

    // Simultaneous rise and aux request: CPU first, aux waits for phi2 low.
    aux_start(16'h0100, 8'h00, 1'b1);
    cpu_rise(16'h0020, 8'h11, 1'b0);
    @(negedge clk);
    check("sim_cpu_first", {o_mem_en0, o_mem_we0, o_mem_addr0}, {2'b11, 16'h0020});
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      early = early | o_aux_ack0;
    end
    check("sim_no_early_ack", early, 0);
    i_cpu_phi2 = 1'b0;
    ok = 1'b0; rd = 8'h00;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (o_aux_ack0) begin
        ok = 1'b1;
        rd = o_aux_rdata0;
      end
    end
    i_aux_req = 1'b0;
    check("sim_aux_after", {ok, rd}, {1'b1, 8'h77});
    repeat (2) @(negedge clk);

    // Reset while in AUX_ACC abandons the access.
    aux_start(16'h0010, 8'h00, 1'b1);
    @(negedge clk);
    check("rstmid_in_acc", o_mem_en0, 1);
    i_reset_n = 1'b0;
    i_aux_req = 1'b0;
    a0 = ack_cnt0;
    @(negedge clk);
    check("rstmid_outputs", {o_mem_en0, o_mem_we0, o_aux_ack0, o_aux_rdata0, o_cpu_data0},
          0);
    i_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_ack", ack_cnt0 - a0, 0);
    check("rstmid_idle", {o_mem_en0, o_mem_addr0}, 0);

    // Access counters after 3 CPU and 2 aux in-window accesses.
    for (int i = 0; i < 3; i++) cpu_access(16'h0010, 8'h00, 1'b1);
    aux_xfer(16'h0004, 8'h00, 1'b1, ok, rd);
    aux_xfer(16'h0005, 8'h00, 1'b1, ok, rd);
`ifdef BRAM_ARB_STATS_EN
    check("stat_cpu", o_stat_cpu0, 16'd3);
    check("stat_aux", o_stat_aux0, 16'd2);
`else
    check("stat_cpu", o_stat_cpu0, 16'd0);
    check("stat_aux", o_stat_aux0, 16'd0);
`endif
    check("we_without_en", we_viol, 0);

    // Saturating counter: increment, preload, saturate, clear.
    sc_inc = 1'b1;
    repeat (3) @(negedge clk);
    sc_inc = 1'b0;
    check("sc_inc3", sc_cnt, 16'd3);
    sc_ld = 1'b1; sc_val = 16'hFFFE;
    @(negedge clk);
    sc_ld = 1'b0; sc_inc = 1'b1;
    @(negedge clk);
    check("sc_reach_max", sc_cnt, 16'hFFFF);
    @(negedge clk);
    check("sc_saturate", sc_cnt, 16'hFFFF);
    sc_inc = 1'b0; sc_clr = 1'b1;
    @(negedge clk);
    check("sc_clear", sc_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_arb.md
BRAM_ARB -- requirements
Module: bram_arb

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000, first byte address of the memory window.
REQ-002 SHALL have parameter SIZE, default 8192, window size in bytes (power of two).
REQ-003 SHALL have ports i_clk in 1, the single clock, and i_reset_n in 1, synchronous active-low reset.
REQ-004 SHALL have CPU ports: i_cpu_phi2 in 1; i_cpu_addr in 16; i_cpu_data in 8 (write data); i_cpu_rw in 1 (1=read); o_cpu_data out 8 (read data).
REQ-005 SHALL have aux ports: i_aux_req in 1; i_aux_addr in 16; i_aux_wdata in 8; i_aux_rw in 1; o_aux_ack out 1; o_aux_rdata out 8.
REQ-006 SHALL have memory ports: o_mem_en out 1; o_mem_we out 1; o_mem_addr out 16 (window offset); o_mem_wdata out 8; i_mem_rdata in 8 (valid one cycle after o_mem_en).
REQ-007 SHALL have o_stat_cpu out 16 and o_stat_aux out 16, access counters.

Function
REQ-008 SHALL detect a CPU access on a phi2 rise: i_cpu_phi2=1 while its registered copy is 0.
REQ-009 SHALL use FSM states IDLE, CPU_ACC, CPU_RESP, AUX_ACC, AUX_RESP; all memory outputs SHALL be registered.
REQ-010 On a phi2 rise in IDLE, SHALL enter CPU_ACC next cycle: o_mem_en=1, o_mem_we=!i_cpu_rw, o_mem_addr=i_cpu_addr-BASE_ADDR, o_mem_wdata=i_cpu_data, all sampled at the rise edge.
REQ-011 CPU_ACC SHALL go to CPU_RESP; CPU_RESP SHALL latch i_mem_rdata into o_cpu_data on reads, then return to IDLE; o_cpu_data valid 2 cycles after the rise edge and held until the next CPU read.
REQ-012 A CPU address outside [BASE_ADDR, BASE_ADDR+SIZE) SHALL cause no memory access, SHALL leave o_cpu_data unchanged and SHALL not count.
REQ-013 From IDLE with phi2 low, no pending rise and i_aux_req=1, SHALL enter AUX_ACC, driving memory from the aux ports.
REQ-014 AUX_ACC SHALL go to AUX_RESP; AUX_RESP SHALL pulse o_aux_ack for exactly one cycle, present o_aux_rdata (read data, or 0 on writes), then return to IDLE.
REQ-015 An out-of-window aux request SHALL ack in AUX_RESP with o_aux_rdata=0 and no memory enable.
REQ-016 Requester SHALL hold i_aux_req and its fields until the ack; the cycle after the ack, i_aux_req=1 is a new request.
REQ-017 A phi2 rise during AUX_ACC/AUX_RESP SHALL set a pending flag; the aux access SHALL complete, then CPU_ACC SHALL follow directly from AUX_RESP, using CPU fields captured at the rise.
REQ-018 A simultaneous phi2 rise and aux request in IDLE SHALL grant the CPU; the aux request SHALL be granted after CPU_RESP if phi2 is low.
REQ-019 Worst-case CPU latency, rise to o_cpu_data valid, SHALL be 4 cycles; phi2 high time SHALL be at least 5 i_clk cycles.
REQ-020 o_mem_en SHALL be high in CPU_ACC/AUX_ACC only; o_mem_we SHALL be 0 whenever o_mem_en=0.

Reset
REQ-021 Reset SHALL force IDLE, clear the pending flag and phi2 copy, and zero o_cpu_data, o_aux_ack, o_aux_rdata, all o_mem_*, and both counters.
REQ-022 Reset mid-access SHALL abandon it: no ack and no further memory enable.

Configuration
REQ-023 With BRAM_ARB_STATS_EN defined, o_stat_cpu/o_stat_aux SHALL count completed in-window CPU/aux accesses and saturate at 16'hFFFF.
REQ-024 Without BRAM_ARB_STATS_EN, o_stat_cpu/o_stat_aux SHALL be constant 0 and no counter logic is built.

Structure
REQ-025 Package bram_arb_pkg SHALL hold the FSM state enum and STAT_W=16.
REQ-026 The counters SHALL be instances of the sub-module sat_counter, with increment and synchronous clear.

Verification
REQ-027 CPU read: mem[0x0010]=0xA5, BASE=0, phi2 rise with addr 0x0010, rw=1 -> one o_mem_en, addr 0x0010, we=0; o_cpu_data=0xA5 at rise+2.
REQ-028 CPU write: addr 0x1FFF, data 0x3C, rw=0 -> one o_mem_en, we=1, wdata 0x3C; later read of 0x1FFF returns 0x3C.
REQ-029 Collision: aux read of 0x0004 enters AUX_ACC, phi2 rises next cycle -> aux ack (rdata=mem[4]), then CPU_ACC immediately; o_cpu_data valid within 4 cycles.
REQ-030 Out of window: BASE=16'h1000, CPU addr 0x3000 -> no o_mem_en, o_cpu_data unchanged; aux addr 0x0FFF -> ack, rdata 0x00, no o_mem_en.
REQ-031 Reset in AUX_ACC -> no ack, o_mem_en=0 the next cycle, all outputs 0, state IDLE.
REQ-032 With BRAM_ARB_STATS_EN: 3 CPU + 2 aux in-window accesses -> o_stat_cpu=3, o_stat_aux=2; counter preloaded to 16'hFFFF stays 16'hFFFF after another access.
